// File: rtl/img_pkg.sv
// Shared definitions for the image streaming blocks: default pixel width,
// counter width helper and the flat window element index.
package img_pkg;

   localparam int DEF_PIX_W = 8;

   // Counter width for a range of n positions; never narrower than one bit.
   function automatic int ctr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Element (r,c) of a KxK window, r=0 top row, c=0 left column.
   function automatic int win_idx(input int r, input int c, input int k);
      return r * k + c;
   endfunction

endpackage

// File: rtl/line_buf_ram.sv
// One line of pixel storage: combinational read, synchronous write, so a read
// and a write to the same address in one cycle return the old pixel.
module line_buf_ram
   import img_pkg::*;
#(
   parameter int PIX_W = DEF_PIX_W,
   parameter int DEPTH = 256
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [ctr_w(DEPTH)-1:0]   wr_addr,
   input  logic [PIX_W-1:0]          wr_data,
   input  logic [ctr_w(DEPTH)-1:0]   rd_addr,
   output logic [PIX_W-1:0]          rd_data
);

   logic [PIX_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sliding_window_gen.sv
// Streaming KxK window generator: raster pixels in, one window per accepted
// pixel out once K-1 lines and K-1 columns of history are available.
module sliding_window_gen
   import img_pkg::*;
#(
   parameter int PIX_W = DEF_PIX_W,
   parameter int IMG_W = 256,
   parameter int IMG_H = 256,
   parameter int K     = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_sof,
   input  logic [PIX_W-1:0]          in_pix,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [K*K*PIX_W-1:0]      out_win,
   output logic [ctr_w(IMG_H)-1:0]   out_row,
   output logic [ctr_w(IMG_W)-1:0]   out_col,
   output logic                      frame_done
);

   localparam int ROW_W = ctr_w(IMG_H);
   localparam int COL_W = ctr_w(IMG_W);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_WIN0 = ROW_W'(K - 1);
   localparam logic [COL_W-1:0] COL_WIN0 = COL_W'(K - 1);

   logic             accept;
   logic             emit;
   logic [ROW_W-1:0] row_q, row_d, cur_row;
   logic [COL_W-1:0] col_q, col_d, cur_col;

   logic [PIX_W-1:0] lb_rd   [K-1];
   logic [PIX_W-1:0] lb_wd   [K-1];
   logic [PIX_W-1:0] new_col [K];
   logic [PIX_W-1:0] win_q   [K][K];
   logic [PIX_W-1:0] win_d   [K][K];
   logic [K*K*PIX_W-1:0] win_flat;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // A start-of-frame pixel is placed at (0,0) no matter where the counters are.
   assign cur_row = in_sof ? '0 : row_q;
   assign cur_col = in_sof ? '0 : col_q;
   assign emit    = accept && (cur_row >= ROW_WIN0) && (cur_col >= COL_WIN0);

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (accept) begin
         if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
         end else begin
            col_d = cur_col + COL_W'(1);
            row_d = cur_row;
         end
      end
   end

   // Line buffer j holds the line j+1 above the incoming pixel; each buffer
   // passes its old pixel down to the next one as it is overwritten.
   always_comb begin
      lb_wd[0] = in_pix;
      for (int j = 1; j < K - 1; j++) begin
         lb_wd[j] = lb_rd[j-1];
      end
   end

   for (genvar j = 0; j < K - 1; j++) begin : g_lb
      line_buf_ram #(
         .PIX_W (PIX_W),
         .DEPTH (IMG_W)
      ) u_ram (
         .clk     (clk),
         .we      (accept),
         .wr_addr (cur_col),
         .wr_data (lb_wd[j]),
         .rd_addr (cur_col),
         .rd_data (lb_rd[j])
      );
   end

   always_comb begin
      for (int r = 0; r < K - 1; r++) begin
         new_col[r] = lb_rd[K-2-r];
      end
      new_col[K-1] = in_pix;
   end

   always_comb begin
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) begin
            win_d[r][c] = win_q[r][c+1];
         end
         win_d[r][K-1] = new_col[r];
      end
   end

   always_comb begin
      win_flat = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            win_flat[win_idx(r, c, K)*PIX_W +: PIX_W] = win_d[r][c];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         row_q      <= '0;
         col_q      <= '0;
         win_q      <= '{default: '0};
         out_valid  <= 1'b0;
         out_win    <= '0;
         out_row    <= '0;
         out_col    <= '0;
         frame_done <= 1'b0;
      end else begin
         row_q      <= row_d;
         col_q      <= col_d;
         frame_done <= accept && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
         if (accept) begin
            win_q <= win_d;
         end
         // A new window overrides the pending one; otherwise hold until taken.
         if (emit) begin
            out_valid <= 1'b1;
            out_win   <= win_flat;
            out_row   <= cur_row - ROW_WIN0;
            out_col   <= cur_col - COL_WIN0;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
